mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs: aluop, rd_data, rd_addr, mem_addr, rd_enable.
- Performs loads and stores over the byte-wide synchronous RAM port using a byte-serial FSM. Produces registered writeback fields for the MEM/WB register.
- Raises stall_req_o so the controller holds the EX/MEM register (stall_signal[3]) and all earlier stages while an access is in flight.

Parameters:
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- aluop_i  in  `OpCodeLen  operation from EX/MEM. Memory ops are `LB `LH `LW `LBU `LHU `SB `SH `SW; all other ops pass through.
- rd_data_i  in  32  ALU result; store data for stores.
- rd_addr_i  in  5  destination register.
- mem_addr_i  in  32  effective address.
- rd_enable_i  in  1  writeback enable.
- mem_din_i  in  8  RAM read data; valid the cycle after the address is presented.
- rd_data_o  out  32  writeback data.
- rd_addr_o  out  5  writeback register.
- rd_enable_o  out  1  writeback enable.
- mem_a_o  out  ADDR_W  RAM address (registered).
- mem_dout_o  out  8  RAM write data (registered).
- mem_wr_o  out  1  RAM write strobe (registered).
- stall_req_o  out  1  hold request to the pipeline controller (combinational).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; state IDLE; byte counter 0.
  - Reset mid-access aborts immediately; mem_wr_o drops without waiting for a clock.
- States: IDLE, BUSY.
- N = access width in bytes: 1 for B/BU, 2 for H/HU, 4 for W.
- IDLE, non-memory op:
  - stall_req_o=0.
  - Next edge: rd_data_o, rd_addr_o, rd_enable_o take the inputs (latency 1).
  - mem_wr_o=0.
- IDLE, memory op (call this cycle 0):
  - stall_req_o=1 combinationally.
  - Edge: latch op, addr, data, rd_addr; mem_a_o<=addr; mem_wr_o<=is_store; mem_dout_o<=data[7:0]; cnt<=1; go to BUSY.
- BUSY, store:
  - Cycle j (1..N-1): mem_a_o<=addr+j; mem_dout_o<=data[8j+7:8j]; cnt++.
  - Cycle N: stall_req_o=0; the last byte is on the bus this cycle. Edge: mem_wr_o<=0, rd_enable_o<=0, go to IDLE.
  - stall_req_o is high in cycles 0..N-1.
- BUSY, load:
  - mem_wr_o=0 throughout.
  - Address addr+k is presented in cycle k+1; mem_din_i is captured into byte k in cycle k+2.
  - Cycle N+1: stall_req_o=0. Edge: rd_data_o<=assembled value; rd_addr_o and rd_enable_o<=latched values; go to IDLE.
  - stall_req_o is high in cycles 0..N.
- Byte order and extension:
  - Little-endian: byte 0 is at the lowest address.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Addresses: addr+k wraps modulo 2^ADDR_W.
- Cycle after completion: the FSM is in IDLE and sees the next EX/MEM contents. Back-to-back memory ops start immediately with no bubble.
- In BUSY, inputs are ignored; all operands come from latched copies.
- While BUSY, rd_*_o hold their previous values; rd_enable_o is not re-asserted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is not started: no RAM strobe, stall_req_o=0.
  - Next edge: misalign_o<=1, rd_enable_o<=0, stay IDLE.
  - misalign_o<=0 on any other accepted op.
- Undefined: no port; misaligned accesses are performed byte-serially like any other access.

Test Plan:
- Reset: rst_n low mid-BUSY store (cycle 2 of `SW) -> mem_wr_o=0 asynchronously; all outputs 0; state IDLE after release.
- Pass-through: aluop=ADD, rd_data=0x1234, rd_addr=5, rd_enable=1 -> next edge rd_data_o=0x1234, rd_addr_o=5, rd_enable_o=1; stall_req_o never high.
- `SW` addr=0x100, data=0xA1B2C3D4 -> writes 0xD4@0x100, 0xC3@0x101, 0xB2@0x102, 0xA1@0x103 on consecutive cycles; stall_req_o high 4 cycles; rd_enable_o=0.
- `LB` and `LBU` at 0x200 holding 0x80 -> rd_data_o=0xFFFFFF80 and 0x00000080 respectively; stall_req_o high 2 cycles each.
- `LH` at 0x0000FFFF, ADDR_W=16, bytes 0x34@0xFFFF and 0x12@0x0000 -> wrap to 0x0000; rd_data_o=0x00001234; stall high 3 cycles.
- Back-to-back `SW` then `LW` to the same address -> the load returns the stored word; the load's first address is presented on the edge after the store completes.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: byte-serial load/store FSM over a byte-wide synchronous RAM, registered writeback fields.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses and raises misalign_o.
`ifndef OpCodeLen
`define OpCodeLen 6
`endif
`ifndef LB
`define LB  6'h10
`endif
`ifndef LH
`define LH  6'h11
`endif
`ifndef LW
`define LW  6'h12
`endif
`ifndef LBU
`define LBU 6'h13
`endif
`ifndef LHU
`define LHU 6'h14
`endif
`ifndef SB
`define SB  6'h15
`endif
`ifndef SH
`define SH  6'h16
`endif
`ifndef SW
`define SW  6'h17
`endif

module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`OpCodeLen-1:0] aluop_i,
    input  logic [31:0]           rd_data_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  rd_enable_i,
    input  logic [7:0]            mem_din_i,
    output logic [31:0]           rd_data_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_enable_o,
    output logic [ADDR_W-1:0]     mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  misalign_o,
`endif
    output logic                  stall_req_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        width_q, width_d;
    logic              isStore_q, isStore_d;
    logic              signExt_q, signExt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        rdAddrLat_q, rdAddrLat_d;
    logic              rdEnLat_q, rdEnLat_d;
    logic [23:0]       loadBuf_q, loadBuf_d;
    logic [31:0]       rdData_d;
    logic [4:0]        rdAddr_d;
    logic              rdEn_d;
    logic [ADDR_W-1:0] memA_d;
    logic [7:0]        memDout_d;
    logic              memWr_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic              misalign_d;
`endif

    logic              isMemIn, isStoreIn, signIn, misalignIn, startMem, lastCycle;
    logic [2:0]        widthIn;
    logic [31:0]       loadValue;

    always_comb begin
        isMemIn   = 1'b1;
        isStoreIn = 1'b0;
        signIn    = 1'b0;
        widthIn   = 3'd1;
        case (aluop_i)
            `LB:  signIn = 1'b1;
            `LBU: widthIn = 3'd1;
            `LH:  begin widthIn = 3'd2; signIn = 1'b1; end
            `LHU: widthIn = 3'd2;
            `LW:  widthIn = 3'd4;
            `SB:  isStoreIn = 1'b1;
            `SH:  begin widthIn = 3'd2; isStoreIn = 1'b1; end
            `SW:  begin widthIn = 3'd4; isStoreIn = 1'b1; end
            default: isMemIn = 1'b0;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalignIn = isMemIn && ((widthIn == 3'd2 && mem_addr_i[0]) ||
                                    (widthIn == 3'd4 && mem_addr_i[1:0] != 2'b00));
`else
    assign misalignIn = 1'b0;
`endif
    assign startMem = isMemIn && !misalignIn;

    // Stores finish once the last byte is on the bus; loads need one more cycle for its read data.
    assign lastCycle = isStore_q ? (cnt_q == width_q) : (cnt_q == width_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startMem) state_d = BUSY;
            BUSY:    if (lastCycle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_req_o = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) stall_req_o = startMem;
            else                 stall_req_o = !lastCycle;
        end
    end

    // The final load byte is taken straight from the RAM port on the completing edge.
    always_comb begin
        case (width_q)
            3'd1:    loadValue = {{24{signExt_q & mem_din_i[7]}}, mem_din_i};
            3'd2:    loadValue = {{16{signExt_q & mem_din_i[7]}}, mem_din_i, loadBuf_q[7:0]};
            default: loadValue = {mem_din_i, loadBuf_q};
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        width_d     = width_q;
        isStore_d   = isStore_q;
        signExt_d   = signExt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdAddrLat_d = rdAddrLat_q;
        rdEnLat_d   = rdEnLat_q;
        loadBuf_d   = loadBuf_q;
        rdData_d    = rd_data_o;
        rdAddr_d    = rd_addr_o;
        rdEn_d      = rd_enable_o;
        memA_d      = mem_a_o;
        memDout_d   = mem_dout_o;
        memWr_d     = mem_wr_o;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d  = misalign_o;
`endif
        if (state_q == IDLE) begin
            if (startMem) begin
                width_d     = widthIn;
                isStore_d   = isStoreIn;
                signExt_d   = signIn;
                addr_d      = mem_addr_i[ADDR_W-1:0];
                data_d      = rd_data_i;
                rdAddrLat_d = rd_addr_i;
                rdEnLat_d   = rd_enable_i;
                memA_d      = mem_addr_i[ADDR_W-1:0];
                memWr_d     = isStoreIn;
                memDout_d   = rd_data_i[7:0];
                cnt_d       = 3'd1;
`ifdef MEM_ALIGN_CHECK_EN
                misalign_d  = 1'b0;
`endif
            end else if (misalignIn) begin
                rdEn_d  = 1'b0;
                memWr_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                misalign_d = 1'b1;
`endif
            end else begin
                rdData_d = rd_data_i;
                rdAddr_d = rd_addr_i;
                rdEn_d   = rd_enable_i;
                memWr_d  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                misalign_d = 1'b0;
`endif
            end
        end else if (lastCycle) begin
            memWr_d = 1'b0;
            cnt_d   = 3'd0;
            if (isStore_q) begin
                rdEn_d = 1'b0;
            end else begin
                rdData_d = loadValue;
                rdAddr_d = rdAddrLat_q;
                rdEn_d   = rdEnLat_q;
            end
        end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < width_q) begin
                memA_d = addr_q + ADDR_W'(cnt_q);
                case (cnt_q)
                    3'd1:    memDout_d = data_q[15:8];
                    3'd2:    memDout_d = data_q[23:16];
                    default: memDout_d = data_q[31:24];
                endcase
            end
            if (!isStore_q) begin
                case (cnt_q)
                    3'd2:    loadBuf_d[7:0]   = mem_din_i;
                    3'd3:    loadBuf_d[15:8]  = mem_din_i;
                    3'd4:    loadBuf_d[23:16] = mem_din_i;
                    default: loadBuf_d = loadBuf_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            width_q     <= '0;
            isStore_q   <= 1'b0;
            signExt_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rdAddrLat_q <= '0;
            rdEnLat_q   <= 1'b0;
            loadBuf_q   <= '0;
            rd_data_o   <= '0;
            rd_addr_o   <= '0;
            rd_enable_o <= 1'b0;
            mem_a_o     <= '0;
            mem_dout_o  <= '0;
            mem_wr_o    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            isStore_q   <= isStore_d;
            signExt_q   <= signExt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdAddrLat_q <= rdAddrLat_d;
            rdEnLat_q   <= rdEnLat_d;
            loadBuf_q   <= loadBuf_d;
            rd_data_o   <= rdData_d;
            rd_addr_o   <= rdAddr_d;
            rd_enable_o <= rdEn_d;
            mem_a_o     <= memA_d;
            mem_dout_o  <= memDout_d;
            mem_wr_o    <= memWr_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o  <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model, byte RAM, random plus directed ops.
`ifndef OpCodeLen
`define OpCodeLen 6
`endif
`ifndef LB
`define LB  6'h10
`endif
`ifndef LH
`define LH  6'h11
`endif
`ifndef LW
`define LW  6'h12
`endif
`ifndef LBU
`define LBU 6'h13
`endif
`ifndef LHU
`define LHU 6'h14
`endif
`ifndef SB
`define SB  6'h15
`endif
`ifndef SH
`define SH  6'h16
`endif
`ifndef SW
`define SW  6'h17
`endif

module tb_mem_stage;
    localparam int ADDR_W = 16;
    localparam int HALF = 5;
    localparam logic [`OpCodeLen-1:0] OP_ADD = 6'h00;
    localparam logic [`OpCodeLen-1:0] OP_XOR = 6'h21;

    logic clk = 1'b0;
    logic rst_n;
    logic [`OpCodeLen-1:0] aluop_i;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] mem_addr_i;
    logic        rd_enable_i;
    logic [7:0]  memDin;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic        stall_req_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
    logic        expMis;
`endif

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .aluop_i(aluop_i), .rd_data_i(rd_data_i),
        .rd_addr_i(rd_addr_i), .mem_addr_i(mem_addr_i), .rd_enable_i(rd_enable_i),
        .mem_din_i(memDin), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_enable_o(rd_enable_o), .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o),
        .mem_wr_o(mem_wr_o),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .stall_req_o(stall_req_o)
    );

    always #HALF clk = ~clk;

    int passCount = 0;
    int checkCount = 0;

    // Expected values for the current cycle, set by the driver at each falling edge
    logic        chkOn = 1'b0;
    logic        expStall, expWr, chkA, chkDout, expRdEn;
    logic [15:0] expA;
    logic [7:0]  expDout;
    logic [31:0] expRdData;
    logic [4:0]  expRdAddr;
    logic        pinValid = 1'b0;
    logic [31:0] pinData;
    string       pinName;

    logic [7:0] ram    [0:65535];
    logic [7:0] shadow [0:65535];
    logic [7:0] rdNext;

    function automatic logic [7:0] initByte(input int a);
        int h;
        h = a * 37 + 11 + (a >>> 8);
        return h[7:0];
    endfunction

    // Byte-wide synchronous RAM: samples the port just before each rising edge, read data one cycle later
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = initByte(i);
        forever begin
            @(negedge clk);
            #(HALF-1);
            rdNext = ram[mem_a_o];
            if (mem_wr_o === 1'b1) ram[mem_a_o] = mem_dout_o;
            @(posedge clk);
            memDin <= rdNext;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput();
        chk("stall_req_o", 32'(stall_req_o), 32'(expStall));
        chk("mem_wr_o", 32'(mem_wr_o), 32'(expWr));
        if (chkA) chk("mem_a_o", 32'(mem_a_o), 32'(expA));
        if (chkDout) chk("mem_dout_o", 32'(mem_dout_o), 32'(expDout));
        chk("rd_data_o", rd_data_o, expRdData);
        chk("rd_addr_o", 32'(rd_addr_o), 32'(expRdAddr));
        chk("rd_enable_o", 32'(rd_enable_o), 32'(expRdEn));
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_o", 32'(misalign_o), 32'(expMis));
`endif
        if (pinValid) begin
            chk(pinName, rd_data_o, pinData);
            pinValid = 1'b0;
        end
    endtask

    // One compare process, a little after every falling edge
    initial forever begin
        @(negedge clk);
        #1;
        if (chkOn) checkOutput();
    end

    // Presents one EX/MEM op for as many cycles as the model says it occupies, then updates the model
    task automatic applyStimulus(input logic [`OpCodeLen-1:0] op, input logic [31:0] data,
                                 input logic [4:0] rdA, input logic [31:0] addr, input logic rdEn,
                                 input int abortAt, input int pinStall);
        int n = 1;
        int dur;
        int stallSeen = 0;
        bit isMem = 1, isStore = 0, sgn = 0, mis = 0;
        logic [15:0] a16 = addr[15:0];
        logic [31:0] val;
        case (op)
            `LB:  sgn = 1;
            `LBU: n = 1;
            `LH:  begin n = 2; sgn = 1; end
            `LHU: n = 2;
            `LW:  n = 4;
            `SB:  isStore = 1;
            `SH:  begin n = 2; isStore = 1; end
            `SW:  begin n = 4; isStore = 1; end
            default: isMem = 0;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        mis = isMem && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
`endif
        dur = (!isMem || mis) ? 1 : (isStore ? n + 1 : n + 2);
        for (int c = 0; c < dur; c++) begin
            @(negedge clk);
            if (c == 0) begin
                aluop_i = op; rd_data_i = data; rd_addr_i = rdA;
                mem_addr_i = addr; rd_enable_i = rdEn;
            end else begin
                aluop_i = 6'($urandom); rd_data_i = $urandom; rd_addr_i = 5'($urandom);
                mem_addr_i = $urandom; rd_enable_i = 1'($urandom);
            end
            expStall = (c < dur - 1);
            expWr    = isStore && !mis && c >= 1 && c <= n;
            chkA     = isMem && !mis && c >= 1 && c <= n;
            expA     = a16 + 16'(c - 1);
            chkDout  = expWr;
            if (expWr) expDout = data[8*(c-1) +: 8];
            if (c == abortAt) begin
                #3 rst_n = 1'b0;
                #1;
                chk("reset_async_mem_wr", 32'(mem_wr_o), 32'h0);
                chk("reset_stall", 32'(stall_req_o), 32'h0);
                chk("reset_mem_a", 32'(mem_a_o), 32'h0);
                chk("reset_mem_dout", 32'(mem_dout_o), 32'h0);
                chk("reset_rd_data", rd_data_o, 32'h0);
                chk("reset_rd_enable", 32'(rd_enable_o), 32'h0);
                for (int k = 0; k < abortAt - 1; k++) shadow[16'(a16 + 16'(k))] = data[8*k +: 8];
                expRdData = '0; expRdAddr = '0; expRdEn = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                expMis = 1'b0;
`endif
                aluop_i = OP_ADD; rd_data_i = '0; rd_addr_i = '0; mem_addr_i = '0; rd_enable_i = 1'b0;
                expStall = 1'b0; expWr = 1'b0; chkA = 1'b0; chkDout = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            #2;
            if (stall_req_o === 1'b1) stallSeen++;
        end
        if (pinStall >= 0) chk("stall_cycles", 32'(stallSeen), 32'(pinStall));
        if (!isMem) begin
            expRdData = data; expRdAddr = rdA; expRdEn = rdEn;
`ifdef MEM_ALIGN_CHECK_EN
            expMis = 1'b0;
        end else if (mis) begin
            expRdEn = 1'b0; expMis = 1'b1;
`endif
        end else if (isStore) begin
            for (int k = 0; k < n; k++) shadow[16'(a16 + 16'(k))] = data[8*k +: 8];
            expRdEn = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            expMis = 1'b0;
`endif
        end else begin
            val = '0;
            for (int k = 0; k < n; k++) val[8*k +: 8] = shadow[16'(a16 + 16'(k))];
            if (sgn && n == 1) val = {{24{val[7]}}, val[7:0]};
            if (sgn && n == 2) val = {{16{val[15]}}, val[15:0]};
            expRdData = val; expRdAddr = rdA; expRdEn = rdEn;
`ifdef MEM_ALIGN_CHECK_EN
            expMis = 1'b0;
`endif
        end
    endtask

    task automatic pin(input string name, input logic [31:0] value);
        pinName = name; pinData = value; pinValid = 1'b1;
    endtask

    function automatic logic [`OpCodeLen-1:0] pickOp(input int i);
        case (i)
            0: return `LB;
            1: return `LH;
            2: return `LW;
            3: return `LBU;
            4: return `LHU;
            5: return `SB;
            6: return `SH;
            7: return `SW;
            8: return OP_ADD;
            default: return OP_XOR;
        endcase
    endfunction

    initial begin
        int lhStall;
        logic [31:0] rAddr;
        for (int i = 0; i < 65536; i++) shadow[i] = initByte(i);
        rst_n = 1'b0;
        aluop_i = OP_ADD; rd_data_i = '0; rd_addr_i = '0; mem_addr_i = '0; rd_enable_i = 1'b0;
        expStall = 1'b0; expWr = 1'b0; chkA = 1'b0; chkDout = 1'b0; expA = '0; expDout = '0;
        expRdData = '0; expRdAddr = '0; expRdEn = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        expMis = 1'b0;
`endif
        chkOn = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 32'h1234, 5'd5, 32'h0, 1'b1, -1, 0);
        pin("passthrough_rd_data", 32'h0000_1234);
        applyStimulus(`SW, 32'hA1B2_C3D4, 5'd7, 32'h100, 1'b1, -1, 4);
        applyStimulus(`LW, 32'h0, 5'd9, 32'h100, 1'b1, -1, 5);
        pin("lw_after_sw", 32'hA1B2_C3D4);
        applyStimulus(`SB, 32'h0000_0080, 5'd1, 32'h200, 1'b0, -1, 1);
        applyStimulus(`LB, 32'h0, 5'd2, 32'h200, 1'b1, -1, 2);
        pin("lb_sign_ext", 32'hFFFF_FF80);
        applyStimulus(`LBU, 32'h0, 5'd3, 32'h200, 1'b1, -1, 2);
        pin("lbu_zero_ext", 32'h0000_0080);
        applyStimulus(`SB, 32'h0000_0034, 5'd1, 32'h0000_FFFF, 1'b0, -1, 1);
        applyStimulus(`SB, 32'h0000_0012, 5'd1, 32'h0000_0000, 1'b0, -1, 1);
`ifdef MEM_ALIGN_CHECK_EN
        lhStall = 0;
`else
        lhStall = 3;
`endif
        applyStimulus(`LH, 32'h0, 5'd4, 32'h0000_FFFF, 1'b1, -1, lhStall);
`ifndef MEM_ALIGN_CHECK_EN
        pin("lh_wrap", 32'h0000_1234);
`endif
        applyStimulus(`SW, 32'hCAFE_F00D, 5'd6, 32'h300, 1'b1, 2, -1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rAddr = $urandom;
                1:       rAddr = 32'h0000_FFF8 + 32'($urandom_range(0, 15));
                default: rAddr = 32'h0000_0F00 + 32'($urandom_range(0, 31));
            endcase
            applyStimulus(pickOp($urandom_range(0, 9)), $urandom, 5'($urandom), rAddr,
                          1'($urandom), -1, -1);
        end
        applyStimulus(OP_ADD, 32'h0, 5'd0, 32'h0, 1'b0, -1, 0);
        @(negedge clk);
        #2;
        chkOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
